// File: rtl/oscilo_pkg.sv
// Shared types and constants for the oscilloscope capture/readout blocks.
package oscilo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_FETCH,
        ST_SEND_WAIT,
        ST_CHECKSUM,
        ST_FINISH,
        ST_DONE
    } reader_state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; start bit drives txd two cycles after tx_start.
// tx_start is only accepted while tx_busy is low; tx_busy drops as the stop bit ends.
module uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [9:0]    shift;
    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic          loading;

    // The accept cycle only captures the byte; the start bit goes out on the following edge.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            loading <= 1'b0;
            shift   <= '1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                shift   <= {1'b1, tx_data, 1'b0};
                tx_busy <= 1'b1;
                loading <= 1'b1;
            end
        end else if (loading) begin
            txd     <= shift[0];
            shift   <= {1'b1, shift[9:1]};
            loading <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                txd     <= shift[0];
                shift   <= {1'b1, shift[9:1]};
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sample_reader.sv
// Streams sample memory as one UART frame: 0xA5, every sample, then the mod-256 sample sum.
// First start bit two cycles after busy rises; each byte waits for the transmitter to go idle.
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [7:0]            mem_data,
    output logic                  txd
);

    reader_state_t         state, state_nxt;
    reader_state_t         ret_state, ret_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            checksum;
    logic                  tx_start;
    logic                  tx_busy;
    logic [7:0]            tx_data;

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
        end
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            checksum <= '0;
        end else if (state == ST_IDLE && activate) begin
            addr     <= '0;
            checksum <= '0;
        end else if (state == ST_FETCH) begin
            addr     <= addr + 1'b1;
            checksum <= checksum + mem_data;
        end
    end

    // Every byte (header, sample, checksum) leaves from a state entered straight after an idle TX,
    // so all inter-byte gaps come out identical.
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        tx_start  = 1'b0;
        tx_data   = mem_data;
        mem_oe    = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (activate) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                tx_start  = 1'b1;
                tx_data   = FRAME_HEADER;
                ret_nxt   = ST_FETCH;
                state_nxt = ST_SEND_WAIT;
            end
            ST_FETCH: begin
                mem_oe    = 1'b1;
                tx_start  = 1'b1;
                ret_nxt   = (addr == '1) ? ST_CHECKSUM : ST_FETCH;
                state_nxt = ST_SEND_WAIT;
            end
            ST_SEND_WAIT: begin
                if (!tx_busy) state_nxt = ret_state;
            end
            ST_CHECKSUM: begin
                tx_start  = 1'b1;
                tx_data   = checksum;
                ret_nxt   = ST_FINISH;
                state_nxt = ST_SEND_WAIT;
            end
            ST_FINISH: begin
                if (!tx_busy) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!activate) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_addr = addr;

    uart_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_tx (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .txd       (txd)
    );

endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader: 4-sample memory, 10 clocks per UART bit.
module tb_sample_reader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int AW     = 2;

    logic          clk_50mhz = 1'b0;
    logic          reset     = 1'b0;
    logic          activate  = 1'b0;
    logic          done, busy, mem_oe, txd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [7:0]    mem [4];

    int checks = 0;
    int passes = 0;

    logic [7:0] got [6];
    bit         framed [6];
    int         gaps [6];
    int         rx_count;

    int            oe_count = 0;
    logic [AW-1:0] oe_addr [$];

    always #5 clk_50mhz = ~clk_50mhz;

    assign mem_data = mem[mem_addr];

    always @(negedge clk_50mhz) begin
        if (mem_oe === 1'b1) begin
            oe_count++;
            oe_addr.push_back(mem_addr);
        end
    end

    sample_reader #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .activate  (activate),
        .done      (done),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_data  (mem_data),
        .txd       (txd)
    );

    // Decodes one byte starting at a negedge; waited = high cycles seen before the start bit.
    task automatic rx_byte(input int budget, output logic [7:0] b, output bit ok,
                           output bit tmo, output int waited);
        logic s [100];
        logic e;
        waited = 0;
        tmo    = 1'b0;
        ok     = 1'b1;
        b      = 'x;
        while (txd !== 1'b0 && waited < budget) begin
            @(negedge clk_50mhz);
            waited++;
        end
        if (txd !== 1'b0) begin
            tmo = 1'b1;
            ok  = 1'b0;
            return;
        end
        for (int c = 0; c < 100; c++) begin
            s[c] = txd;
            @(negedge clk_50mhz);
        end
        for (int i = 0; i < 8; i++) b[i] = s[(i + 1) * 10 + 5];
        for (int c = 0; c < 100; c++) begin
            if (c < 10)       e = 1'b0;
            else if (c >= 90) e = 1'b1;
            else              e = b[c / 10 - 1];
            if (s[c] !== e) ok = 1'b0;
        end
    endtask

    task automatic rx_frame(input int first_budget);
        logic [7:0] b;
        bit ok, tmo;
        int w;
        rx_count = 0;
        for (int i = 0; i < 6; i++) begin
            got[i] = 'x; framed[i] = 1'b0; gaps[i] = -1;
        end
        for (int i = 0; i < 6; i++) begin
            rx_byte((i == 0) ? first_budget : 20, b, ok, tmo, w);
            got[i] = b; framed[i] = ok; gaps[i] = w;
            rx_count = i + 1;
            if (tmo) break;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 6) begin
            @(negedge clk_50mhz);
            n++;
        end
    endtask

    task automatic test_reset();
        int lows = 0;
        int busies = 0;
        #1 reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (mem_oe !== 1'b0) $display("FAIL reset_mem_oe: got %b want 0", mem_oe); else passes++;
        checks++; if (mem_addr !== 2'd0) $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); else passes++;
        repeat (2) @(negedge clk_50mhz);
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_50mhz);
            if (txd !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        checks++; if (lows != 0) $display("FAIL idle_txd: got %0d low cycles want 0", lows); else passes++;
        checks++; if (busies != 0) $display("FAIL idle_busy: got %0d busy cycles want 0", busies); else passes++;
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        int n;
        mem = '{8'h01, 8'h02, 8'h03, 8'h04};
        @(negedge clk_50mhz);
        activate = 1'b1;
        @(negedge clk_50mhz);
        checks++; if (busy !== 1'b1) $display("FAIL basic_start_busy: got %b want 1", busy); else passes++;
        rx_frame(10);
        checks++; if (gaps[0] != 2) $display("FAIL basic_start_latency: got %0d want 2", gaps[0]); else passes++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i] || !framed[i])
                $display("FAIL basic_byte%0d: got %h framed=%0d want %h framed=1", i, got[i], framed[i], exp[i]);
            else passes++;
        end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (gaps[i] < 0 || gaps[i] > 3) $display("FAIL basic_gap%0d: got %0d want 0..3", i, gaps[i]);
            else passes++;
        end
        checks++; if (gaps[1] != gaps[2]) $display("FAIL basic_hdr_gap: got %0d want %0d", gaps[1], gaps[2]); else passes++;
        wait_done(n);
        checks++; if (done !== 1'b1 || n > 2) $display("FAIL basic_done_rise: got done=%b after %0d want 1 within 2", done, n); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy); else passes++;
        repeat (20) @(negedge clk_50mhz);
        checks++; if (done !== 1'b1) $display("FAIL basic_done_hold: got %b want 1", done); else passes++;
        activate = 1'b0;
        @(negedge clk_50mhz);
        checks++; if (done !== 1'b0) $display("FAIL basic_done_release: got %b want 0", done); else passes++;
    endtask

    task automatic test_checksum_wrap();
        logic [7:0] exp [6] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        int n;
        mem = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        activate = 1'b1;
        @(negedge clk_50mhz);
        rx_frame(10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i] || !framed[i])
                $display("FAIL wrap_byte%0d: got %h framed=%0d want %h framed=1", i, got[i], framed[i], exp[i]);
            else passes++;
        end
        wait_done(n);
        activate = 1'b0;
        @(negedge clk_50mhz);
    endtask

    task automatic test_glitch();
        logic [7:0] exp [6] = '{8'hA5, 8'h80, 8'h40, 8'h20, 8'h11, 8'hF1};
        int dcount = 0;
        int lows = 0;
        mem = '{8'h80, 8'h40, 8'h20, 8'h11};
        rx_count = 0;
        activate = 1'b1;
        @(negedge clk_50mhz);
        activate = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", busy); else passes++;
        fork
            rx_frame(10);
            begin
                int guard = 0;
                while (rx_count < 2 && guard < 2000) begin
                    @(negedge clk_50mhz);
                    guard++;
                end
                repeat (20) @(negedge clk_50mhz);
                activate = 1'b1;
                @(negedge clk_50mhz);
                activate = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i] || !framed[i])
                $display("FAIL glitch_byte%0d: got %h framed=%0d want %h framed=1", i, got[i], framed[i], exp[i]);
            else passes++;
        end
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dcount++;
            @(negedge clk_50mhz);
        end
        checks++; if (dcount != 1) $display("FAIL glitch_done_width: got %0d cycles want 1", dcount); else passes++;
        for (int i = 0; i < 300; i++) begin
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
            @(negedge clk_50mhz);
        end
        checks++; if (lows != 0) $display("FAIL glitch_no_second_frame: got %0d active cycles want 0", lows); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [6] = '{8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
        logic [7:0] b;
        bit ok, tmo;
        int w, n;
        int lows = 0;
        mem = '{8'h01, 8'h02, 8'h03, 8'h04};
        activate = 1'b1;
        @(negedge clk_50mhz);
        rx_byte(10, b, ok, tmo, w);
        rx_byte(20, b, ok, tmo, w);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(negedge clk_50mhz);
            n++;
        end
        checks++; if (txd !== 1'b0) $display("FAIL mid_byte3_start: got %b want 0", txd); else passes++;
        repeat (3) @(negedge clk_50mhz);
        #2 reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL mid_reset_txd: got %b want 1", txd); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passes++;
        @(negedge clk_50mhz);
        activate = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50mhz);
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows != 0) $display("FAIL mid_no_resume: got %0d low cycles want 0", lows); else passes++;
        mem = '{8'h05, 8'h06, 8'h07, 8'h08};
        activate = 1'b1;
        @(negedge clk_50mhz);
        rx_frame(10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i] || !framed[i])
                $display("FAIL mid_restart_byte%0d: got %h framed=%0d want %h framed=1", i, got[i], framed[i], exp[i]);
            else passes++;
        end
        wait_done(n);
        activate = 1'b0;
        @(negedge clk_50mhz);
    endtask

    task automatic test_addr_sweep();
        int n;
        mem = '{8'h10, 8'h20, 8'h30, 8'h40};
        @(negedge clk_50mhz);
        oe_count = 0;
        oe_addr.delete();
        activate = 1'b1;
        @(negedge clk_50mhz);
        rx_frame(10);
        checks++; if (got[5] !== 8'hA0) $display("FAIL sweep_checksum: got %h want a0", got[5]); else passes++;
        wait_done(n);
        checks++; if (done !== 1'b1) $display("FAIL sweep_done: got %b want 1", done); else passes++;
        checks++; if (mem_addr !== 2'd0) $display("FAIL sweep_addr_at_done: got %0d want 0", mem_addr); else passes++;
        checks++; if (oe_count != 4) $display("FAIL sweep_oe_count: got %0d want 4", oe_count); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= oe_addr.size()) $display("FAIL sweep_addr%0d: got none want %0d", i, i);
            else if (oe_addr[i] !== AW'(i)) $display("FAIL sweep_addr%0d: got %0d want %0d", i, oe_addr[i], i);
            else passes++;
        end
        activate = 1'b0;
        @(negedge clk_50mhz);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum_wrap();
        test_glitch();
        test_reset_mid();
        test_addr_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sample_reader.md
# sample_reader

Downstream stage of the sampler: once a capture is in sample memory, this block walks the memory from address 0 to the top and streams every sample to the host over UART TX as one framed packet, with a header byte and a checksum. It sits beside `sampler` under the top-level state watcher, is started by `sample_reader_activate` and reports through `sample_reader_done`. It drives the read port of the sample RAM, which has an asynchronous read.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `BAUD`, 115200, UART bit rate. Divider `DIV = CLK_HZ / BAUD`, truncated (434 at defaults).
- `ADDR_WIDTH`, 8, sample-memory address width. `DEPTH = 2**ADDR_WIDTH`. Data width is fixed at 8.

Ports:
- `clk_50mhz`  in  1  system clock. This is the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `activate`  in  1  start request, level-sensitive, sampled only in IDLE.
- `done`  out  1  frame finished.
- `busy`  out  1  high from the accepted `activate` until `done` rises.
- `mem_addr`  out  ADDR_WIDTH  sample RAM read address.
- `mem_oe`  out  1  sample RAM output enable.
- `mem_data`  in  8  sample RAM read data, valid combinationally in the same cycle as `mem_addr`.
- `txd`  out  1  UART serial out: 8N1, LSB first, idles high.

## Operation
- Frame: header `0xA5`, then `mem[0] … mem[DEPTH-1]`, then a checksum. Total `DEPTH+2` bytes.
- Checksum is the sum of all samples mod 256. The header is excluded. The accumulator clears when a frame starts.
- State machine:
  - IDLE: `activate=1` → HEADER.
  - HEADER: load `0xA5` into the TX → SEND_WAIT(next=FETCH).
  - FETCH: `mem_oe=1`; latch `mem_data` into the TX and add it to the checksum; increment `mem_addr` → SEND_WAIT. After address `DEPTH-1`, `mem_addr` wraps to 0 and next=CHECKSUM.
  - SEND_WAIT: wait until the TX is idle, then go to next.
  - CHECKSUM: load the checksum into the TX → SEND_WAIT(next=FINISH).
  - FINISH: wait until the TX is idle, then → DONE.
  - DONE: `done=1`. Hold it while `activate=1`; when `activate=0` → IDLE.
- If `activate` drops mid-frame, the frame still completes. `done` is then high for exactly 1 cycle.
- If `activate` is re-asserted while busy, it is ignored. A new frame requires passing through IDLE.
- Reset mid-frame aborts immediately:
  - `txd` goes to 1 asynchronously and no partial byte is continued.
  - After reset is released, the block waits in IDLE for `activate`.
- `mem_oe=0` and `mem_addr` is held outside FETCH.

## Timing
- Reset values:
  - `txd=1`, `done=0`, `busy=0`, `mem_oe=0`, `mem_addr=0`.
  - State IDLE, checksum 0.
- Start latency:
  - `activate` is sampled high at edge k.
  - `busy=1` after edge k.
  - `txd` falls (start bit) after edge k+2.
- Each bit is exactly `DIV` cycles and each byte exactly `10*DIV` cycles. The stop bit is one full bit.
- The gap between consecutive bytes (stop end → next start) is at most 3 cycles.
  - Required: the header-to-sample gap equals the sample-to-sample gap.
- `done` rises within 2 cycles after the checksum's stop bit ends. `busy` falls in the same cycle.
- Total frame time is about `(DEPTH+2)*10*DIV` cycles, which is 1,119,720 at defaults plus gaps.

## Structure
- Shared package `oscilo_pkg`:
  - state enum `reader_state_t`
  - `FRAME_HEADER = 8'hA5`
- One sub-module, `uart_tx`, is the sibling of `uart_rx`.
  - Parameters: `CLK_HZ` and `BAUD`.
  - Ports: `clk_50mhz`, `reset`, `tx_start`, `tx_data[7:0]`, `tx_busy`, `txd`.
  - Accepts `tx_start` only when `!tx_busy`. `tx_busy` rises the cycle after `tx_start`.
- The reader FSM, address counter and checksum accumulator live in `sample_reader`.

## Test plan
Bench parameters: `CLK_HZ=1_000_000`, `BAUD=100_000` (`DIV=10`), `ADDR_WIDTH=2` (4 samples).

- Reset: assert `reset` → `txd=1`, `done=0`, `busy=0`, `mem_oe=0`, `mem_addr=0` with no clock edge. Release reset with `activate=0` → `txd` stays 1 for 1000 cycles.
- Basic frame: mem={01,02,03,04}, `activate` held high.
  - UART monitor decodes A5 01 02 03 04 0A.
  - Every bit is 10 cycles, start=0, stop=1, LSB first.
  - `done` stays high until `activate` drops, then IDLE.
- Checksum wrap: mem={FF,FF,FF,FF} → decoded A5 FF FF FF FF FC.
- Activate glitch: `activate` is a 1-cycle pulse → full 6-byte frame, `done` high exactly 1 cycle. Re-pulse `activate` during byte 3 → no second frame.
- Reset mid-frame: assert `reset` during the start bit of byte 3 → `txd=1` asynchronously and no further bytes. Then `activate` again → full frame starting with A5, checksum correct (not carried over).
- Address sweep: check that `mem_oe` pulses exactly 4 times per frame, with `mem_addr` 0,1,2,3 and then back to 0 at `done`.
